instruction_fetch: RTL and testbench

Fetch stage between the flash/NVRAM bus and the `control_matrix` soft CPU. On a request it reads the four bytes of a 26-bit instruction starting at a 16-bit instruction pointer and assembles them. It holds the assembled instruction under a valid/ready handshake until the CPU consumes it. It drives the byte-wide memory bus chip controls: flash on address bit 15 = 1, NVRAM on bit 15 = 0. It never writes memory.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_wait_timer.sv | 44 ++++
 rtl/instruction_fetch.sv | 144 ++++++++++++++
 tb/tb_instruction_fetch.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and byte-lane layout for the instruction fetch stage
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BYTE = 2'd1,
        HOLD = 2'd2
    } fetchState_t;

    localparam int INSTR_BYTES = 4;
    // Address bit that selects flash (1) versus NVRAM (0).
    localparam int DEV_SEL_BIT = 15;

    // Instruction bit positions of each fetched byte; byte3 fills the bits
    // below BYTE_LANE_BASE.
    localparam int BYTE0_LSB      = 24;
    localparam int BYTE0_WIDTH    = 2;
    localparam int BYTE1_LSB      = 16;
    localparam int BYTE2_LSB      = 8;
    localparam int BYTE_LANE_BASE = 8;

    // Bytes 0..2 are collected here before byte3 completes the instruction.
    localparam int PARTIAL_W = BYTE0_LSB + BYTE0_WIDTH - BYTE_LANE_BASE;

endpackage

// File: rtl/fetch_wait_timer.sv
// rtl/fetch_wait_timer.sv - per-byte wait-state down-counter with done pulse
//
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   load           : start a new WAIT_CYCLES interval
//   clear          : abandon the running interval (clear wins over load)
//   done           : high during the last cycle of the interval
module fetch_wait_timer #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic load,
    input  logic clear,
    output logic done
);

    localparam logic [3:0] RELOAD = 4'(WAIT_CYCLES - 1);

    logic [3:0] count;
    logic       armed;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            armed <= 1'b0;
        end else if (clear) begin
            count <= '0;
            armed <= 1'b0;
        end else if (load) begin
            count <= RELOAD;
            armed <= 1'b1;
        end else if (armed) begin
            if (count == 4'd0) begin
                armed <= 1'b0;
            end else begin
                count <= count - 4'd1;
            end
        end
    end

    assign done = armed && (count == 4'd0);

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetches and assembles 26-bit instructions from the flash/NVRAM byte bus
//
// Ports:
//   clock, reset_n          : clock and asynchronous active-low reset
//   fetch_ip                : instruction byte address, taken on request accept
//   req_valid / req_ready   : fetch request handshake
//   flush                   : discard any fetch in progress or held instruction
//   instr / instr_valid /
//   instr_ready             : assembled instruction handshake towards the CPU
//   mem_addr, mem_data      : byte-wide memory bus
//   p_oe_n, p_we_n          : flash output/write enable, active-low
//   t_oe_n, t_we_n          : NVRAM output/write enable, active-low
//   busy                    : stage is driving the memory bus
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int INSTR_W     = 26,
    parameter int WAIT_CYCLES = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [ADDR_W-1:0]  fetch_ip,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               flush,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [7:0]         mem_data,
    output logic               p_oe_n,
    output logic               p_we_n,
    output logic               t_oe_n,
    output logic               t_we_n,
    output logic               busy
);

    fetchState_t          state;
    logic [1:0]           byteIdx;
    logic [ADDR_W-1:0]    ipLatched;
    logic [ADDR_W-1:0]    nextAddr;
    logic [PARTIAL_W-1:0] partial;
    logic                 accept;
    logic                 lastByte;
    logic                 timerDone;
    logic                 timerLoad;
    logic                 timerClear;

    // This stage only ever reads memory.
    assign p_we_n = 1'b1;
    assign t_we_n = 1'b1;

    assign accept   = (state == IDLE) && req_valid && req_ready && !flush;
    assign lastByte = (byteIdx == 2'(INSTR_BYTES - 1));
    // Wraps naturally at the top of the address space.
    assign nextAddr = ipLatched + ADDR_W'(byteIdx) + ADDR_W'(1);

    assign timerLoad  = accept || ((state == BYTE) && timerDone && !lastByte && !flush);
    assign timerClear = flush || ((state == BYTE) && timerDone && lastByte);

    fetch_wait_timer #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_timer (
        .clock  (clock),
        .reset_n(reset_n),
        .load   (timerLoad),
        .clear  (timerClear),
        .done   (timerDone)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            byteIdx     <= '0;
            ipLatched   <= '0;
            partial     <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            req_ready   <= 1'b0;
            mem_addr    <= '0;
            p_oe_n      <= 1'b1;
            t_oe_n      <= 1'b1;
            busy        <= 1'b0;
        end else if (flush) begin
            // Flush beats a simultaneous request or consume.
            state       <= IDLE;
            instr       <= '0;
            instr_valid <= 1'b0;
            req_ready   <= 1'b1;
            p_oe_n      <= 1'b1;
            t_oe_n      <= 1'b1;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= BYTE;
                        byteIdx   <= '0;
                        ipLatched <= fetch_ip;
                        mem_addr  <= fetch_ip;
                        p_oe_n    <= !fetch_ip[DEV_SEL_BIT];
                        t_oe_n    <= fetch_ip[DEV_SEL_BIT];
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                BYTE: begin
                    if (timerDone) begin
                        case (byteIdx)
                            2'd0: partial[BYTE0_LSB-BYTE_LANE_BASE +: BYTE0_WIDTH] <= mem_data[BYTE0_WIDTH-1:0];
                            2'd1: partial[BYTE1_LSB-BYTE_LANE_BASE +: 8] <= mem_data;
                            2'd2: partial[BYTE2_LSB-BYTE_LANE_BASE +: 8] <= mem_data;
                            2'd3: instr <= INSTR_W'({partial, mem_data});
                        endcase
                        if (lastByte) begin
                            state       <= HOLD;
                            instr_valid <= 1'b1;
                            p_oe_n      <= 1'b1;
                            t_oe_n      <= 1'b1;
                            busy        <= 1'b0;
                        end else begin
                            byteIdx  <= byteIdx + 2'd1;
                            mem_addr <= nextAddr;
                            p_oe_n   <= !nextAddr[DEV_SEL_BIT];
                            t_oe_n   <= nextAddr[DEV_SEL_BIT];
                        end
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        state       <= IDLE;
                        instr_valid <= 1'b0;
                        req_ready   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch with one and three wait cycles
module tb_instruction_fetch;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic [15:0] fetchIp    [2];
    logic        reqValid   [2];
    logic        reqReady   [2];
    logic        flush      [2];
    logic [25:0] instr      [2];
    logic        instrValid [2];
    logic        instrReady [2];
    logic [15:0] memAddr    [2];
    logic [7:0]  memData    [2];
    logic        pOeN       [2];
    logic        pWeN       [2];
    logic        tOeN       [2];
    logic        tWeN       [2];
    logic        busy       [2];

    logic [7:0]  memArr [65536];

    int checks   = 0;
    int failures = 0;

    // Memory answers only when the enable of the addressed device is active.
    assign memData[0] = (memAddr[0][15] ? !pOeN[0] : !tOeN[0]) ? memArr[memAddr[0]] : 8'h5A;
    assign memData[1] = (memAddr[1][15] ? !pOeN[1] : !tOeN[1]) ? memArr[memAddr[1]] : 8'h5A;

    instruction_fetch #(.ADDR_W(16), .INSTR_W(26), .WAIT_CYCLES(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .fetch_ip(fetchIp[0]), .req_valid(reqValid[0]),
        .req_ready(reqReady[0]), .flush(flush[0]), .instr(instr[0]), .instr_valid(instrValid[0]),
        .instr_ready(instrReady[0]), .mem_addr(memAddr[0]), .mem_data(memData[0]),
        .p_oe_n(pOeN[0]), .p_we_n(pWeN[0]), .t_oe_n(tOeN[0]), .t_we_n(tWeN[0]), .busy(busy[0])
    );

    instruction_fetch #(.ADDR_W(16), .INSTR_W(26), .WAIT_CYCLES(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .fetch_ip(fetchIp[1]), .req_valid(reqValid[1]),
        .req_ready(reqReady[1]), .flush(flush[1]), .instr(instr[1]), .instr_valid(instrValid[1]),
        .instr_ready(instrReady[1]), .mem_addr(memAddr[1]), .mem_data(memData[1]),
        .p_oe_n(pOeN[1]), .p_we_n(pWeN[1]), .t_oe_n(tOeN[1]), .t_we_n(tWeN[1]), .busy(busy[1])
    );

    function automatic int waitOf(input int s);
        return (s == 0) ? 1 : 3;
    endfunction

    // Reference: four consecutive bytes (wrapping), byte0 keeps only its low two bits.
    function automatic logic [25:0] modelInstr(input logic [15:0] ip);
        logic [7:0]  b [4];
        logic [15:0] a;
        for (int k = 0; k < 4; k++) begin
            a    = ip + 16'(k);
            b[k] = memArr[a];
        end
        return {b[0][1:0], b[1], b[2], b[3]};
    endfunction

    task automatic wait_ready(input int s, input string tag);
        int n = 0;
        while (reqReady[s] !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (reqReady[s] !== 1'b1) begin
            failures++;
            $display("FAIL %s req_ready_timeout got=%b exp=1", tag, reqReady[s]);
        end
    endtask

    task automatic start_fetch(input int s, input logic [15:0] ip);
        fetchIp[s]  = ip;
        reqValid[s] = 1'b1;
        @(posedge clock);
        #1 reqValid[s] = 1'b0;
    endtask

    task automatic fetch_and_check(input int s, input logic [15:0] ip, input int holdCycles,
                                   input string tag, output logic [25:0] got);
        int          w        = waitOf(s);
        logic [25:0] expInstr = modelInstr(ip);
        logic [15:0] expAddr;
        wait_ready(s, tag);
        start_fetch(s, ip);
        for (int c = 1; c <= 4 * w; c++) begin
            @(negedge clock);
            expAddr = ip + 16'((c - 1) / w);
            checks++;
            if (memAddr[s] !== expAddr) begin
                failures++;
                $display("FAIL %s addr cyc=%0d got=%h exp=%h", tag, c, memAddr[s], expAddr);
            end
            checks++;
            if ({pOeN[s], tOeN[s]} !== {!expAddr[15], expAddr[15]}) begin
                failures++;
                $display("FAIL %s oe cyc=%0d got=%b%b exp=%b%b", tag, c, pOeN[s], tOeN[s], !expAddr[15], expAddr[15]);
            end
            checks++;
            if ({busy[s], instrValid[s], reqReady[s], pWeN[s], tWeN[s]} !== 5'b10011) begin
                failures++;
                $display("FAIL %s ctl cyc=%0d got=%b%b%b%b%b exp=10011", tag, c,
                         busy[s], instrValid[s], reqReady[s], pWeN[s], tWeN[s]);
            end
        end
        @(negedge clock);
        checks++;
        if (instrValid[s] !== 1'b1) begin
            failures++;
            $display("FAIL %s valid_rise cyc=%0d got=%b exp=1", tag, 4 * w + 1, instrValid[s]);
        end
        checks++;
        if (instr[s] !== expInstr) begin
            failures++;
            $display("FAIL %s instr got=%h exp=%h", tag, instr[s], expInstr);
        end
        checks++;
        if ({pOeN[s], tOeN[s], busy[s]} !== 3'b110) begin
            failures++;
            $display("FAIL %s hold_bus got=%b%b%b exp=110", tag, pOeN[s], tOeN[s], busy[s]);
        end
        got = instr[s];
        for (int h = 0; h < holdCycles; h++) begin
            @(negedge clock);
            checks++;
            if (instrValid[s] !== 1'b1 || instr[s] !== expInstr || reqReady[s] !== 1'b0) begin
                failures++;
                $display("FAIL %s hold cyc=%0d got=%b/%h/%b exp=1/%h/0", tag, h,
                         instrValid[s], instr[s], reqReady[s], expInstr);
            end
        end
        instrReady[s] = 1'b1;
        @(posedge clock);
        #1 instrReady[s] = 1'b0;
        @(negedge clock);
        checks++;
        if ({instrValid[s], reqReady[s]} !== 2'b01) begin
            failures++;
            $display("FAIL %s release got=%b%b exp=01", tag, instrValid[s], reqReady[s]);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ({reqReady[s], instrValid[s], busy[s], pOeN[s], pWeN[s], tOeN[s], tWeN[s]} !== 7'b0001111
                || instr[s] !== 26'd0 || memAddr[s] !== 16'd0) begin
                failures++;
                $display("FAIL reset_values dut=%0d got=%b%b%b%b%b%b%b/%h/%h exp=0001111/0/0", s,
                         reqReady[s], instrValid[s], busy[s], pOeN[s], pWeN[s], tOeN[s], tWeN[s],
                         instr[s], memAddr[s]);
            end
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (reqReady[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_before_edge got=%b exp=0", reqReady[0]);
        end
        @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (reqReady[s] !== 1'b1) begin
                failures++;
                $display("FAIL reset_ready_first_edge dut=%0d got=%b exp=1", s, reqReady[s]);
            end
        end
    endtask

    task automatic test_basic_flash();
        logic [25:0] got;
        memArr[16'h8000] = 8'h03;
        memArr[16'h8001] = 8'hAB;
        memArr[16'h8002] = 8'hCD;
        memArr[16'h8003] = 8'hEF;
        fetch_and_check(0, 16'h8000, 0, "basic", got);
        checks++;
        if (got !== 26'h3ABCDEF) begin
            failures++;
            $display("FAIL basic_const got=%h exp=3abcdef", got);
        end
    endtask

    task automatic test_straddle();
        logic [25:0] got;
        fetch_and_check(0, 16'h7FFE, 1, "straddle_w1", got);
        fetch_and_check(1, 16'h7FFE, 0, "straddle_w3", got);
    endtask

    task automatic test_wrap();
        logic [25:0] got;
        fetch_and_check(0, 16'hFFFE, 0, "wrap_w1", got);
        fetch_and_check(1, 16'hFFFF, 2, "wrap_w3", got);
    endtask

    task automatic test_wait_backpressure();
        logic [25:0] got;
        fetch_and_check(1, 16'($urandom), 10, "wait_backpressure", got);
    endtask

    task automatic test_flush();
        logic [25:0] got;
        logic [15:0] ip = 16'h8050;
        // Mid-fetch flush during byte2.
        wait_ready(0, "flush_mid");
        start_fetch(0, ip);
        repeat (3) @(negedge clock);
        checks++;
        if (memAddr[0] !== ip + 16'd2) begin
            failures++;
            $display("FAIL flush_at_byte2 got=%h exp=%h", memAddr[0], ip + 16'd2);
        end
        flush[0] = 1'b1;
        @(posedge clock);
        #1 flush[0] = 1'b0;
        @(negedge clock);
        checks++;
        if ({instrValid[0], pOeN[0], tOeN[0], busy[0], reqReady[0]} !== 5'b01101) begin
            failures++;
            $display("FAIL flush_mid_after got=%b%b%b%b%b exp=01101",
                     instrValid[0], pOeN[0], tOeN[0], busy[0], reqReady[0]);
        end
        for (int k = 0; k < 4; k++) memArr[16'h8100 + 16'(k)] = 8'($urandom);
        fetch_and_check(0, 16'h8100, 0, "flush_refetch", got);
        checks++;
        if (got !== modelInstr(16'h8100)) begin
            failures++;
            $display("FAIL flush_refetch_data got=%h exp=%h", got, modelInstr(16'h8100));
        end
        // Flush while holding, with instr_ready asserted in the same cycle.
        wait_ready(1, "flush_hold");
        start_fetch(1, 16'h0123);
        repeat (13) @(negedge clock);
        checks++;
        if (instrValid[1] !== 1'b1) begin
            failures++;
            $display("FAIL flush_hold_valid got=%b exp=1", instrValid[1]);
        end
        flush[1]      = 1'b1;
        instrReady[1] = 1'b1;
        @(posedge clock);
        #1 begin flush[1] = 1'b0; instrReady[1] = 1'b0; end
        @(negedge clock);
        checks++;
        if ({instrValid[1], instr[1] != 26'd0, reqReady[1]} !== 3'b001) begin
            failures++;
            $display("FAIL flush_hold_after got=%b/%h/%b exp=0/0/1", instrValid[1], instr[1], reqReady[1]);
        end
        // Flush beats a request offered in the same cycle.
        fetchIp[0]  = 16'h9000;
        reqValid[0] = 1'b1;
        flush[0]    = 1'b1;
        @(posedge clock);
        #1 begin reqValid[0] = 1'b0; flush[0] = 1'b0; end
        repeat (2) @(negedge clock);
        checks++;
        if ({busy[0], pOeN[0], tOeN[0], reqReady[0], instrValid[0]} !== 5'b01110) begin
            failures++;
            $display("FAIL flush_vs_req got=%b%b%b%b%b exp=01110",
                     busy[0], pOeN[0], tOeN[0], reqReady[0], instrValid[0]);
        end
    endtask

    task automatic test_reset_mid_fetch();
        logic [25:0] got;
        logic [15:0] ip = 16'h7FF0;
        wait_ready(1, "reset_mid");
        start_fetch(1, ip);
        repeat (4) @(negedge clock);
        checks++;
        if (memAddr[1] !== ip + 16'd1 || tOeN[1] !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_at_byte1 got=%h/%b exp=%h/0", memAddr[1], tOeN[1], ip + 16'd1);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({pOeN[1], tOeN[1], busy[1], instrValid[1], reqReady[1]} !== 5'b11000
            || memAddr[1] !== 16'd0 || instr[1] !== 26'd0) begin
            failures++;
            $display("FAIL reset_mid_async got=%b%b%b%b%b/%h/%h exp=11000/0/0",
                     pOeN[1], tOeN[1], busy[1], instrValid[1], reqReady[1], memAddr[1], instr[1]);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if ({reqReady[1], busy[1], pOeN[1], tOeN[1]} !== 4'b1011) begin
            failures++;
            $display("FAIL reset_mid_release got=%b%b%b%b exp=1011", reqReady[1], busy[1], pOeN[1], tOeN[1]);
        end
        fetch_and_check(1, 16'($urandom), 1, "reset_refetch", got);
    endtask

    task automatic test_random();
        logic [25:0] got;
        for (int i = 0; i < 12; i++) begin
            fetch_and_check(int'($urandom_range(0, 1)), 16'($urandom), int'($urandom_range(0, 4)),
                            "random", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [25:0] got;
        logic [15:0] ip = 16'($urandom);
        for (int i = 0; i < 4; i++) begin
            fetch_and_check(0, ip, 0, "back_to_back", got);
            ip = ip + 16'd4;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            fetchIp[s]    = 16'd0;
            reqValid[s]   = 1'b0;
            flush[s]      = 1'b0;
            instrReady[s] = 1'b0;
        end
        for (int a = 0; a < 65536; a++) memArr[a] = 8'($urandom);
        test_reset();
        test_basic_flash();
        test_straddle();
        test_wrap();
        test_wait_backpressure();
        test_flush();
        test_reset_mid_fetch();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
